// File: rtl/sync_demod.sv
// Synchronous demodulator: triggers one ADC conversion per generator strobe,
// accumulates samples signed by excitation half-cycle, publishes per-period sums.
module sync_demod #(
  parameter int ADC_W   = 12,
  parameter int ACC_W   = 24,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             start_conv,
  input  logic             new_period,
  input  logic             phase,
  output logic             adc_cnv,
  input  logic             adc_busy,
  input  logic [ADC_W-1:0] adc_data,
  output logic [ACC_W-1:0] result,
  output logic             result_valid,
  output logic [7:0]       sample_count,
  output logic             overrun,
  output logic             timeout_err
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, CNV, WAIT_HI, WAIT_LO, ACC} state_e;

  state_e             state_q;
  logic               sc_prev_q, np_prev_q;
  logic               sign_q, armed_q, close_pend_q;
  logic               adc_cnv_q, result_valid_q, overrun_q, timeout_err_q;
  logic [TMR_W-1:0]   timer_q;
  logic [ADC_W-1:0]   data_q;
  logic [ACC_W-1:0]   acc_q, result_q;
  logic [7:0]         cnt_q, count_q;

  logic               sc_edge, np_edge, do_close;
  logic signed [ADC_W-1:0] sample_s;
  logic [ACC_W-1:0]   sample_ext, acc_d;
  logic [7:0]         cnt_d;

  assign sc_edge  = start_conv & ~sc_prev_q;
  assign np_edge  = new_period & ~np_prev_q;
  // A close requested mid-conversion waits until the sample has been accumulated.
  assign do_close = (state_q == IDLE) && (np_edge || close_pend_q);

  // Offset-binary to two's complement is an MSB flip.
  assign sample_s   = {~data_q[ADC_W-1], data_q[ADC_W-2:0]};
  assign sample_ext = {{(ACC_W-ADC_W){sample_s[ADC_W-1]}}, sample_s};
  assign acc_d      = sign_q ? (acc_q + sample_ext) : (acc_q - sample_ext);
  assign cnt_d      = (cnt_q == 8'hFF) ? cnt_q : (cnt_q + 8'd1);

  // NOTE: every register here uses <= so all updates see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      sc_prev_q      <= 1'b0;
      np_prev_q      <= 1'b0;
      sign_q         <= 1'b0;
      armed_q        <= 1'b0;
      close_pend_q   <= 1'b0;
      adc_cnv_q      <= 1'b0;
      result_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
      timeout_err_q  <= 1'b0;
      timer_q        <= '0;
      data_q         <= '0;
      acc_q          <= '0;
      result_q       <= '0;
      cnt_q          <= '0;
      count_q        <= '0;
    end else begin
      sc_prev_q      <= start_conv;
      np_prev_q      <= new_period;
      adc_cnv_q      <= 1'b0;
      result_valid_q <= 1'b0;

      if (!enable) armed_q <= 1'b0;

      if (do_close) begin
        if (armed_q && enable) begin
          result_q       <= acc_q;
          count_q        <= cnt_q;
          result_valid_q <= 1'b1;
        end
        armed_q      <= enable;
        acc_q        <= '0;
        cnt_q        <= '0;
        close_pend_q <= 1'b0;
      end else if (np_edge && state_q != IDLE) begin
        close_pend_q <= 1'b1;
      end

      if (sc_edge && state_q != IDLE) overrun_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (sc_edge && enable) begin
            state_q   <= CNV;
            adc_cnv_q <= 1'b1;
            sign_q    <= phase;
          end
        end
        CNV: begin
          timer_q <= '0;
          state_q <= WAIT_HI;
        end
        WAIT_HI: begin
          if (adc_busy) begin
            state_q <= WAIT_LO;
          end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
            timeout_err_q <= 1'b1;
            state_q       <= IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        WAIT_LO: begin
          if (!adc_busy) begin
            data_q  <= adc_data;
            state_q <= ACC;
          end
        end
        ACC: begin
          acc_q   <= acc_d;
          cnt_q   <= cnt_d;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign adc_cnv      = adc_cnv_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign sample_count = count_q;
  assign overrun      = overrun_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: doc/sync_demod.md
# sync_demod

Synchronous-demodulation capture block for the sine-excitation acquisition path: consumes the sine generator's per-sample conversion strobe, period marker and half-cycle sign, drives an external ADC through a convert/busy handshake, and accumulates each sample signed by the excitation half-cycle. At every period boundary it publishes the signed per-period sum and conversion count. It is the receiving end of the generator's control outputs, sitting between the generator/DAC side and the downstream result reader.

## Interface
- ADC_W, 12, ADC sample width, offset-binary
- ACC_W, 24, accumulator/result width, two's complement
- TIMEOUT, 255, max clk cycles from adc_cnv to busy rise before the conversion is abandoned
- clk  in  1  system clock; all inputs synchronous to it
- rst  in  1  asynchronous, active-high reset
- enable  in  1  1 = capture permitted
- start_conv  in  1  generator conversion strobe (level); rising edge requests one conversion
- new_period  in  1  generator period marker (level); rising edge closes the current period
- phase  in  1  excitation half-cycle sign: 1 = positive half, 0 = negative half
- adc_cnv  out  1  one-cycle convert pulse to ADC
- adc_busy  in  1  ADC busy, high during conversion
- adc_data  in  ADC_W  ADC result, valid in the cycle busy is seen falling
- result  out  ACC_W  signed sum of the last complete period
- result_valid  out  1  one-cycle pulse when result/sample_count update
- sample_count  out  8  conversions accumulated in the last complete period (saturates at 255)
- overrun  out  1  sticky: start_conv edge arrived while a conversion was in flight
- timeout_err  out  1  sticky: busy never rose within TIMEOUT cycles

## Operation
- Edge detect: registered copies of start_conv and new_period; rising edge = current 1, previous 0. Previous registers reset to 0.
- FSM states: IDLE, CNV, WAIT_HI, WAIT_LO, ACC.
  - IDLE: on start_conv edge with enable=1 -> CNV; latch phase into sign_q.
  - CNV: adc_cnv=1 for this cycle only; clear timer -> WAIT_HI.
  - WAIT_HI: busy=1 -> WAIT_LO; timer reaching TIMEOUT -> set timeout_err, sample dropped, -> IDLE.
  - WAIT_LO: busy=0 -> capture adc_data -> ACC. No timeout in this state.
  - ACC: s = adc_data - 2^(ADC_W-1) sign-extended to ACC_W; acc += s if sign_q=1 else acc -= s; cnt += 1 (saturating) -> IDLE.
- Accumulator wraps modulo 2^ACC_W; no saturation.
- start_conv edge in any state other than IDLE: request ignored, overrun set.
- Period close (new_period edge): result <= acc, sample_count <= cnt, result_valid pulse; acc, cnt <= 0. Published only if armed=1; armed set at every period close while enable=1, cleared when enable=0. First period after reset or after enable rises is discarded (arms only).
- Close pending: new_period edge while FSM in CNV/WAIT_HI/WAIT_LO/ACC is latched and executed in the cycle after ACC (or after timeout exit); the in-flight sample belongs to the closing period.
- Simultaneous new_period and start_conv edges in IDLE: period closes first; the new conversion counts toward the new period.
- enable=0: no new conversions; in-flight conversion completes; acc/cnt cleared on next period close, no result_valid.
- overrun, timeout_err clear only on rst.

## Timing
- Reset: adc_cnv 0, result 0, result_valid 0, sample_count 0, overrun 0, timeout_err 0, FSM IDLE, acc 0, cnt 0, armed 0, close-pending 0.
- start_conv edge detected at cycle N -> adc_cnv high at N+1 (registered output).
- busy seen low at cycle M in WAIT_LO -> accumulator updated at M+1 (ACC), FSM IDLE at M+2.
- new_period edge at N in IDLE -> result/sample_count/result_valid registered at N+1; result_valid low at N+2.
- Deferred close: result_valid in the cycle after ACC completes.
- Timer counts from WAIT_HI entry; abandon on cycle TIMEOUT.

## Test plan
- Basic period: ADC_W=12; 32 start_conv edges, phase=1 for first 16 with adc_data 0xC00, phase=0 for last 16 with 0x400; then new_period edge -> after discarded arming period, result=32768, sample_count=32, result_valid one cycle.
- Handshake: start_conv edge at N -> adc_cnv single pulse at N+1; busy high 10 cycles, data 0x8FF -> acc +255 one cycle after busy falls.
- Overrun: second start_conv edge while in WAIT_LO -> overrun=1, stays 1, no second adc_cnv; sample_count counts 1.
- Deferred close: new_period edge while busy high -> result_valid only after that sample accumulates; sample included in closing result.
- Timeout: busy held 0 after adc_cnv -> timeout_err=1 after 255 cycles, FSM IDLE, acc unchanged, next start_conv edge accepted.
- Async reset mid-conversion (WAIT_LO): all outputs and flags 0 immediately; next period discarded (armed=0).
